ser_to_par_rx: RTL and testbench

- Serial-to-parallel receiver; the receive end of the parallel-to-serial link driven by `top` (valid-qualified single-bit stream, `output_valid`/`out` style).
- Assembles WIDTH serial bits into one parallel word and presents it on a valid/ready output port.
- One-entry output buffer decouples the serial side from downstream backpressure; stalls the serial side when the buffer cannot accept a completed word.

---
 rtl/ser_link_pkg.sv | 13 +
 rtl/ser_to_par_rx_out_buf_reg.sv | 32 +++
 rtl/ser_to_par_rx.sv | 114 +++++++++++
 tb/tb_ser_to_par_rx.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/ser_link_pkg.sv
// Shared types and helpers for the serial link (receiver now, transmitter later).
package ser_link_pkg;

  typedef enum logic {COLLECT, STALL} rx_state_t;

  localparam int DEF_WIDTH = 4;

  // Even-parity bit over up to 16 data bits; callers zero-extend narrower words.
  function automatic logic even_parity(input logic [15:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/ser_to_par_rx_out_buf_reg.sv
// One-entry valid/ready holding register with a load port; load wins over a
// same-edge transfer so a new word can replace the outgoing one with valid held.
module out_buf_reg
  import ser_link_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  input  logic             ready,
  output logic             can_load
);

  assign can_load = !valid || ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/ser_to_par_rx.sv
// Serial-to-parallel receiver with a one-entry output buffer and stall on backpressure.
// Optional even-parity frame check enabled by defining SER_RX_PARITY_EN.
module ser_to_par_rx
  import ser_link_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ser_valid,
  input  logic                       ser_in,
  output logic                       ser_ready,
  output logic                       par_valid,
  output logic [WIDTH-1:0]           par_data,
  input  logic                       par_ready,
`ifdef SER_RX_PARITY_EN
  output logic [$clog2(WIDTH+1)-1:0] bit_cnt,
  output logic                       par_err
`else
  output logic [$clog2(WIDTH)-1:0]   bit_cnt
`endif
);

`ifdef SER_RX_PARITY_EN
  localparam int FRAME = WIDTH + 1;
  localparam int CW    = $clog2(WIDTH + 1);
`else
  localparam int FRAME = WIDTH;
  localparam int CW    = $clog2(WIDTH);
`endif
  localparam logic [CW-1:0] LAST = CW'(FRAME - 1);

  rx_state_t        state, state_nxt;
  logic [WIDTH-1:0] shift, shift_nxt, word, buf_data;
  logic             accept, data_bit, word_done, word_ok, can_load, buf_load;

  always_comb begin
    if (MSB_FIRST) shift_nxt = {shift[WIDTH-2:0], ser_in};
    else           shift_nxt = {ser_in, shift[WIDTH-1:1]};
  end

  // In parity mode the completed word is already in shift when the parity bit arrives.
  always_comb begin
    accept    = ser_valid && ser_ready;
    word_done = accept && (bit_cnt == LAST);
`ifdef SER_RX_PARITY_EN
    data_bit  = (bit_cnt != CW'(WIDTH));
    word      = shift;
    word_ok   = (even_parity(16'(shift)) == ser_in);
`else
    data_bit  = 1'b1;
    word      = shift_nxt;
    word_ok   = 1'b1;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= COLLECT;
      bit_cnt <= '0;
      shift   <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        bit_cnt <= (bit_cnt == LAST) ? '0 : bit_cnt + 1'b1;
        if (data_bit) shift <= shift_nxt;
      end
    end
  end

`ifdef SER_RX_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) par_err <= 1'b0;
    else     par_err <= word_done && !word_ok;
  end
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      COLLECT: if (word_done && word_ok && !can_load) state_nxt = STALL;
      STALL:   if (par_ready) state_nxt = COLLECT;
      default: state_nxt = COLLECT;
    endcase
  end

  // In STALL the buffer is always full, so par_ready alone marks the transfer edge.
  always_comb begin
    ser_ready = (state == COLLECT);
    buf_load  = 1'b0;
    buf_data  = word;
    case (state)
      COLLECT: buf_load = word_done && word_ok && can_load;
      STALL: begin
        buf_load = par_ready;
        buf_data = shift;
      end
      default: ;
    endcase
  end

  out_buf_reg #(.WIDTH(WIDTH)) u_out_buf (
    .clk       (clk),
    .rst       (rst),
    .load      (buf_load),
    .load_data (buf_data),
    .valid     (par_valid),
    .data      (par_data),
    .ready     (par_ready),
    .can_load  (can_load)
  );

endmodule

// File: tb/tb_ser_to_par_rx.sv
// Scoreboard bench for ser_to_par_rx: a word-level model predicts handshake state
// and queues expected words; a negedge monitor checks every output transfer.
module tb_ser_to_par_rx;

  localparam int W   = 4;
  localparam bit MSB = 1'b1;
`ifdef SER_RX_PARITY_EN
  localparam int FRAME = W + 1;
  logic [$clog2(W+1)-1:0] bit_cnt;
  logic                   par_err;
`else
  localparam int FRAME = W;
  logic [$clog2(W)-1:0]   bit_cnt;
`endif

  logic         clk, rst, ser_valid, ser_in, ser_ready, par_valid, par_ready;
  logic [W-1:0] par_data;

  ser_to_par_rx #(.WIDTH(W), .MSB_FIRST(MSB)) dut (
    .clk       (clk),
    .rst       (rst),
    .ser_valid (ser_valid),
    .ser_in    (ser_in),
    .ser_ready (ser_ready),
    .par_valid (par_valid),
    .par_data  (par_data),
    .par_ready (par_ready),
`ifdef SER_RX_PARITY_EN
    .bit_cnt   (bit_cnt),
    .par_err   (par_err)
`else
    .bit_cnt   (bit_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int           n_checks = 0;
  int           n_fail   = 0;
  int           pending  = 0;   // words completed but not yet handed downstream
  int           cur[$];         // bits of the frame in progress
  logic [W-1:0] exp_q[$];
  bit           exp_err  = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_state();
    chk("ser_ready", ser_ready, (pending < 2) ? 1 : 0);
    chk("par_valid", par_valid, (pending > 0) ? 1 : 0);
    chk("bit_cnt", bit_cnt, cur.size());
`ifdef SER_RX_PARITY_EN
    chk("par_err", par_err, exp_err);
`endif
  endtask

  function automatic logic [W-1:0] frame_word();
    logic [W-1:0] w = '0;
    for (int i = 0; i < W; i++) begin
      if (MSB) w[W-1-i] = cur[i][0];
      else     w[i]     = cur[i][0];
    end
    return w;
  endfunction

  // Called just after a rising edge: drive inputs, predict the next edge, check after it.
  task automatic step(input bit sv, input bit b, input bit pr);
    bit rdy, xfer, p;
    ser_valid = sv;
    ser_in    = b;
    par_ready = pr;
    rdy     = (pending < 2);
    xfer    = (pending > 0) && pr;
    exp_err = 1'b0;
    if (sv && rdy) begin
      cur.push_back(int'(b));
      if (cur.size() == FRAME) begin
        p = 1'b0;
        for (int i = 0; i < W; i++) p ^= cur[i][0];
        if (FRAME == W || p == cur[FRAME-1][0]) begin
          exp_q.push_back(frame_word());
          pending++;
        end else begin
          exp_err = 1'b1;
        end
        cur.delete();
      end
    end
    if (xfer) pending--;
    @(posedge clk);
    #1;
    check_state();
  endtask

  task automatic send(input logic [W-1:0] w, input bit pr);
    for (int i = 0; i < W; i++) step(1'b1, MSB ? w[W-1-i] : w[i], pr);
  endtask

  task automatic mid_reset();
    #2;
    rst = 1'b1;
    #1;
    chk("rst_par_valid", par_valid, 0);
    chk("rst_bit_cnt", bit_cnt, 0);
    chk("rst_ser_ready", ser_ready, 1);
    pending = 0;
    cur.delete();
    exp_q.delete();
    exp_err = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_state();
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (!rst && par_valid && par_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL par_data_unexpected: got %0d expected no word", par_data);
        end else begin
          chk("par_data", par_data, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    ser_valid = 1'b0;
    ser_in = 1'b0;
    par_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_par_data", par_data, 0);
    rst = 1'b0;
    check_state();

    // single word, then idle to see valid drop
    send(4'b1010, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    // back-to-back words
    send(4'b1101, 1'b1);
    send(4'b1011, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    // backpressure into STALL, rejected bit, then release
    send(4'b1010, 1'b0);
    send(4'b1101, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    // gaps in ser_valid
    step(1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1);
`ifdef SER_RX_PARITY_EN
    step(1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    // good frame then bad-parity frame
    send(4'b1010, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    send(4'b1010, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1);
`endif
    // reset with a buffered word and a partial word in flight
    send(4'b1010, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    mid_reset();
    send(4'b0110, 1'b1);
    step(1'b0, 1'b0, 1'b1);

    for (int n = 0; n < 3000; n++) begin
      if (n == 1500) mid_reset();
      step($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 2) != 0);
    end
    for (int n = 0; n < 4; n++) step(1'b0, 1'b0, 1'b1);
    chk("drain_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
